// File: rtl/display_sched.sv
// Chooses which of four requesters drives the seven-segment scanner (fixed, timed round-robin or priority)
// and lets a latched error code take over the display until it is acknowledged.
module display_sched #(
   parameter int HOLD_BITS = 20
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  mode,
   input  logic [1:0]  sel,
   input  logic [3:0]  req,
   input  logic [15:0] src_val0,
   input  logic [15:0] src_val1,
   input  logic [15:0] src_val2,
   input  logic [15:0] src_val3,
   input  logic        err_stb,
   input  logic [15:0] err_code,
   input  logic        err_ack,
   output logic [15:0] disp_val,
   output logic [3:0]  disp_dots,
   output logic [1:0]  cur_src,
   output logic        err_pending,
   output logic        err_overrun
);

   typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, ERR = 2'd2} state_t;

   localparam logic [HOLD_BITS-1:0] CNT_ONE = 1;

   state_t               r_state;
   state_t               w_stateNext;
   logic [1:0]           r_mode;
   logic [HOLD_BITS-1:0] r_cnt;
   logic [HOLD_BITS-1:0] w_cntNext;
   logic [1:0]           r_cur;
   logic [1:0]           w_curNext;
   logic [15:0]          r_val;
   logic [15:0]          w_valNext;
   logic [3:0]           r_dots;
   logic [3:0]           w_dotsNext;
   logic [15:0]          r_code;
   logic [15:0]          w_codeNext;
   logic                 r_pend;
   logic                 w_pendNext;
   logic                 r_ovr;
   logic                 w_ovrNext;
   logic [1:0]           w_mode;
   logic                 w_modeChg;
   logic                 w_tick;
   logic                 w_show;
   logic [1:0]           w_pick;
   logic [15:0]          w_srcVal [4];

   function automatic logic [1:0] lowestReq(input logic [3:0] r);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (r[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // First set request after cur in rotating order; falls back to cur itself.
   function automatic logic [1:0] rrNext(input logic [1:0] cur, input logic [3:0] r);
      logic [1:0] idx;
      logic [1:0] cand;
      idx = cur;
      for (int k = 3; k >= 1; k--) begin
         cand = cur + 2'(k);
         if (r[cand]) idx = cand;
      end
      return idx;
   endfunction

   assign w_mode      = (mode == 2'b11) ? 2'b00 : mode;
   assign w_modeChg   = (w_mode != r_mode);
   assign w_tick      = &r_cnt;
   assign w_srcVal[0] = src_val0;
   assign w_srcVal[1] = src_val1;
   assign w_srcVal[2] = src_val2;
   assign w_srcVal[3] = src_val3;

   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_curNext   = r_cur;
      w_valNext   = r_val;
      w_dotsNext  = r_dots;
      w_codeNext  = r_code;
      w_pendNext  = r_pend;
      w_ovrNext   = r_ovr;
      w_show      = 1'b0;
      w_pick      = r_cur;

      case (r_state)
         ERR: begin
            if (err_ack) begin
               w_stateNext = IDLE;
               w_pendNext  = 1'b0;
               w_ovrNext   = 1'b0;
               w_cntNext   = '0;
               w_valNext   = '0;
               w_dotsNext  = '0;
            end else begin
               w_cntNext = r_cnt + CNT_ONE;
               if (w_tick) w_dotsNext = ~r_dots;
            end
         end
         default: begin
            // Dwell only advances in round-robin; a mode switch restarts it.
            w_cntNext = '0;
            case (w_mode)
               2'b00: begin
                  if (req[sel]) begin
                     w_show = 1'b1;
                     w_pick = sel;
                  end
               end
               2'b10: begin
                  if (|req) begin
                     w_show = 1'b1;
                     w_pick = lowestReq(req);
                  end
               end
               default: begin
                  if (|req) begin
                     w_show = 1'b1;
                     if (r_state == IDLE) begin
                        w_pick = lowestReq(req);
                     end else if (!req[r_cur]) begin
                        w_pick = rrNext(r_cur, req);
                     end else if (!w_modeChg) begin
                        w_cntNext = r_cnt + CNT_ONE;
                        if (w_tick) w_pick = rrNext(r_cur, req);
                     end
                  end
               end
            endcase
            if (w_show) begin
               w_stateNext = SHOW;
               w_curNext   = w_pick;
               w_valNext   = w_srcVal[w_pick];
               w_dotsNext  = 4'b0001 << w_pick;
            end else begin
               w_stateNext = IDLE;
               w_valNext   = '0;
               w_dotsNext  = '0;
            end
         end
      endcase

      // A strobe overrides everything, except that a pending error keeps its first code.
      if (err_stb) begin
         if ((r_state == ERR) && !err_ack) begin
            w_ovrNext = 1'b1;
         end else begin
            w_stateNext = ERR;
            w_codeNext  = err_code;
            w_valNext   = err_code;
            w_dotsNext  = 4'b1111;
            w_pendNext  = 1'b1;
            w_ovrNext   = 1'b0;
            w_cntNext   = '0;
            w_curNext   = r_cur;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_mode  <= 2'b00;
         r_cnt   <= '0;
         r_cur   <= 2'd0;
         r_val   <= '0;
         r_dots  <= '0;
         r_code  <= '0;
         r_pend  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_mode  <= w_mode;
         r_cnt   <= w_cntNext;
         r_cur   <= w_curNext;
         r_val   <= w_valNext;
         r_dots  <= w_dotsNext;
         r_code  <= w_codeNext;
         r_pend  <= w_pendNext;
         r_ovr   <= w_ovrNext;
      end
   end

   assign disp_val    = r_val;
   assign disp_dots   = r_dots;
   assign cur_src     = r_cur;
   assign err_pending = r_pend;
   assign err_overrun = r_ovr;

endmodule

// File: tb/tb_display_sched.sv
// Directed bench for display_sched with a 16-cycle dwell; expected values are worked out by hand per step.
module tb_display_sched;

   logic        clk;
   logic        reset_n;
   logic [1:0]  mode;
   logic [1:0]  sel;
   logic [3:0]  req;
   logic [15:0] src_val0;
   logic [15:0] src_val1;
   logic [15:0] src_val2;
   logic [15:0] src_val3;
   logic        err_stb;
   logic [15:0] err_code;
   logic        err_ack;
   logic [15:0] disp_val;
   logic [3:0]  disp_dots;
   logic [1:0]  cur_src;
   logic        err_pending;
   logic        err_overrun;

   int total = 0;
   int bad   = 0;

   display_sched #(.HOLD_BITS(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mode        (mode),
      .sel         (sel),
      .req         (req),
      .src_val0    (src_val0),
      .src_val1    (src_val1),
      .src_val2    (src_val2),
      .src_val3    (src_val3),
      .err_stb     (err_stb),
      .err_code    (err_code),
      .err_ack     (err_ack),
      .disp_val    (disp_val),
      .disp_dots   (disp_dots),
      .cur_src     (cur_src),
      .err_pending (err_pending),
      .err_overrun (err_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_val"},  32'(disp_val),    32'h0);
      checkOutput({tag, "_dots"}, 32'(disp_dots),   32'h0);
      checkOutput({tag, "_cur"},  32'(cur_src),     32'h0);
      checkOutput({tag, "_pend"}, 32'(err_pending), 32'h0);
      checkOutput({tag, "_ovr"},  32'(err_overrun), 32'h0);
   endtask

   initial begin
      reset_n  = 1'b0;
      mode     = 2'b00;
      sel      = 2'd0;
      req      = 4'b0000;
      src_val0 = 16'hAAAA;
      src_val1 = 16'h5555;
      src_val2 = 16'h1234;
      src_val3 = 16'h7777;
      err_stb  = 1'b0;
      err_code = 16'h0000;
      err_ack  = 1'b0;
      #2;
      checkAllZero("reset");
      #10;
      reset_n = 1'b1;

      // Fixed mode
      sel = 2'd2;
      req = 4'b0100;
      applyStimulus(1);
      checkOutput("fix_val",  32'(disp_val),  32'h1234);
      checkOutput("fix_dots", 32'(disp_dots), 32'b0100);
      checkOutput("fix_cur",  32'(cur_src),   32'd2);
      src_val2 = 16'h4321;
      applyStimulus(1);
      checkOutput("fix_live", 32'(disp_val), 32'h4321);
      req = 4'b0000;
      applyStimulus(1);
      checkOutput("fix_idle_val",  32'(disp_val),  32'h0);
      checkOutput("fix_idle_dots", 32'(disp_dots), 32'h0);

      // Round-robin
      mode = 2'b01;
      req  = 4'b1011;
      applyStimulus(1);
      checkOutput("rr_entry_cur",  32'(cur_src),   32'd0);
      checkOutput("rr_entry_val",  32'(disp_val),  32'hAAAA);
      checkOutput("rr_entry_dots", 32'(disp_dots), 32'b0001);
      applyStimulus(15);
      checkOutput("rr_dwell_hold", 32'(cur_src), 32'd0);
      applyStimulus(1);
      checkOutput("rr_step1", 32'(cur_src), 32'd1);
      applyStimulus(16);
      checkOutput("rr_step3", 32'(cur_src), 32'd3);
      applyStimulus(16);
      checkOutput("rr_wrap0", 32'(cur_src), 32'd0);
      applyStimulus(16);
      checkOutput("rr_again1", 32'(cur_src), 32'd1);
      req = 4'b1001;
      applyStimulus(1);
      checkOutput("rr_drop_cur",  32'(cur_src),   32'd3);
      checkOutput("rr_drop_val",  32'(disp_val),  32'h7777);
      checkOutput("rr_drop_dots", 32'(disp_dots), 32'b1000);
      applyStimulus(16);
      checkOutput("rr_after_drop", 32'(cur_src), 32'd0);

      // Priority
      mode = 2'b10;
      req  = 4'b1100;
      applyStimulus(1);
      checkOutput("pri_cur2", 32'(cur_src),  32'd2);
      checkOutput("pri_val2", 32'(disp_val), 32'h4321);
      req = 4'b1101;
      applyStimulus(1);
      checkOutput("pri_cur0", 32'(cur_src),  32'd0);
      checkOutput("pri_val0", 32'(disp_val), 32'hAAAA);
      req = 4'b0000;
      applyStimulus(1);
      checkOutput("pri_idle_val",  32'(disp_val),  32'h0);
      checkOutput("pri_idle_dots", 32'(disp_dots), 32'h0);

      // Error takeover while showing source 1
      mode = 2'b00;
      sel  = 2'd1;
      req  = 4'b0010;
      applyStimulus(1);
      checkOutput("src1_val", 32'(disp_val), 32'h5555);
      err_stb  = 1'b1;
      err_code = 16'hDEAD;
      applyStimulus(1);
      err_stb = 1'b0;
      checkOutput("err_val",  32'(disp_val),    32'hDEAD);
      checkOutput("err_pend", 32'(err_pending), 32'h1);
      checkOutput("err_dots", 32'(disp_dots),   32'hF);
      checkOutput("err_cur",  32'(cur_src),     32'd1);
      applyStimulus(15);
      checkOutput("err_dots_hold", 32'(disp_dots), 32'hF);
      applyStimulus(1);
      checkOutput("err_dots_tick", 32'(disp_dots), 32'h0);
      err_stb  = 1'b1;
      err_code = 16'hBEEF;
      applyStimulus(1);
      err_stb = 1'b0;
      checkOutput("ovr_val",  32'(disp_val),    32'hDEAD);
      checkOutput("ovr_flag", 32'(err_overrun), 32'h1);
      checkOutput("ovr_pend", 32'(err_pending), 32'h1);
      err_ack = 1'b1;
      applyStimulus(1);
      err_ack = 1'b0;
      checkOutput("ack_pend", 32'(err_pending), 32'h0);
      checkOutput("ack_ovr",  32'(err_overrun), 32'h0);
      checkOutput("ack_val",  32'(disp_val),    32'h0);
      applyStimulus(1);
      checkOutput("resume_val",  32'(disp_val),  32'h5555);
      checkOutput("resume_cur",  32'(cur_src),   32'd1);
      checkOutput("resume_dots", 32'(disp_dots), 32'b0010);
      err_ack = 1'b1;
      applyStimulus(1);
      err_ack = 1'b0;
      checkOutput("stray_ack_val",  32'(disp_val),    32'h5555);
      checkOutput("stray_ack_pend", 32'(err_pending), 32'h0);

      // Strobe and ack together while in ERR
      err_stb  = 1'b1;
      err_code = 16'hC0DE;
      applyStimulus(1);
      err_stb = 1'b0;
      applyStimulus(16);
      checkOutput("c0de_dots", 32'(disp_dots), 32'h0);
      err_stb  = 1'b1;
      err_code = 16'h2222;
      applyStimulus(1);
      err_stb = 1'b0;
      checkOutput("c0de_ovr", 32'(err_overrun), 32'h1);
      err_stb  = 1'b1;
      err_ack  = 1'b1;
      err_code = 16'h0001;
      applyStimulus(1);
      err_stb = 1'b0;
      err_ack = 1'b0;
      checkOutput("both_val",  32'(disp_val),    32'h0001);
      checkOutput("both_pend", 32'(err_pending), 32'h1);
      checkOutput("both_ovr",  32'(err_overrun), 32'h0);
      checkOutput("both_dots", 32'(disp_dots),   32'hF);

      // Asynchronous reset in ERR
      #3;
      reset_n = 1'b0;
      #1;
      checkAllZero("rst_err");
      #2;
      reset_n = 1'b1;
      applyStimulus(1);
      checkOutput("post_rst_val", 32'(disp_val), 32'h5555);
      checkOutput("post_rst_cur", 32'(cur_src),  32'd1);

      // Asynchronous reset during rotation
      mode = 2'b01;
      req  = 4'b1011;
      applyStimulus(1);
      checkOutput("rr2_keep", 32'(cur_src), 32'd1);
      applyStimulus(16);
      checkOutput("rr2_step", 32'(cur_src), 32'd3);
      #3;
      reset_n = 1'b0;
      #1;
      checkAllZero("rst_rr");
      #2;
      reset_n = 1'b1;
      applyStimulus(1);
      checkOutput("rr2_reentry_cur", 32'(cur_src),  32'd0);
      checkOutput("rr2_reentry_val", 32'(disp_val), 32'hAAAA);

      // Mode 11 behaves as fixed
      mode = 2'b11;
      sel  = 2'd3;
      req  = 4'b1000;
      applyStimulus(1);
      checkOutput("m3_cur",  32'(cur_src),   32'd3);
      checkOutput("m3_val",  32'(disp_val),  32'h7777);
      checkOutput("m3_dots", 32'(disp_dots), 32'b1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
